// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter letting N_REQ requesters share one UART transmitter, one message at a time.
// Define UART_ARB_TAG_EN to prefix each message with a header byte 0xA0|owner.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy
);

  localparam int unsigned PtrW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] GrantLsb = N_REQ'(1);

  typedef enum logic [2:0] {
    StArb,
    StHold,
    StIssue,
    StWaitLo,
`ifdef UART_ARB_TAG_EN
    StWaitHi,
    StTag
`else
    StWaitHi
`endif
  } state_e;

  state_e            state_q;
  logic [PtrW-1:0]   rr_ptr_q;
  logic [PtrW-1:0]   gidx_q;
  logic [N_REQ-1:0]  grant_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              last_q;

  logic              pick_found;
  logic [PtrW-1:0]   pick_idx;
  int unsigned       cand;
  logic              sel_valid;
  logic              sel_last;
  logic [7:0]        sel_data;
  logic              hold_fire;
  logic [PtrW-1:0]   next_ptr;

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = PtrW'(cand);
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (PtrW'(i) == gidx_q) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  assign hold_fire = (state_q == StHold) && sel_valid && tx_ready;
  assign next_ptr  = (gidx_q == PtrW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;

  assign req_ready = hold_fire ? grant_q : '0;
  assign grant     = grant_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = (state_q != StArb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StArb;
      rr_ptr_q   <= '0;
      gidx_q     <= '0;
      grant_q    <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      tx_valid_q <= 1'b0;
      unique case (state_q)
        StArb: begin
          if (pick_found) begin
            gidx_q  <= pick_idx;
            grant_q <= GrantLsb << pick_idx;
`ifdef UART_ARB_TAG_EN
            state_q <= StTag;
`else
            state_q <= StHold;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        StTag: begin
          if (tx_ready) begin
            tx_data_q  <= 8'hA0 | 8'(gidx_q);
            last_q     <= 1'b0;
            tx_valid_q <= 1'b1;
            state_q    <= StIssue;
          end
        end
`endif
        StHold: begin
          // An owner with nothing to send keeps the grant; no one else is served mid-message.
          if (hold_fire) begin
            tx_data_q  <= sel_data;
            last_q     <= sel_last;
            tx_valid_q <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: state_q <= StWaitLo;
        StWaitLo: begin
          if (!tx_ready) state_q <= StWaitHi;
        end
        StWaitHi: begin
          if (tx_ready) begin
            if (last_q) begin
              state_q  <= StArb;
              grant_q  <= '0;
              rr_ptr_q <= next_ptr;
              last_q   <= 1'b0;
            end else begin
              state_q <= StHold;
            end
          end
        end
        default: state_q <= StArb;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requester sources, a UART timing model and a
// scoreboard of expected (owner, byte) pairs checked at every tx_valid strobe.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int Frame = 10;
`ifdef UART_ARB_TAG_EN
  localparam int TagBytes = 1;
`else
  localparam int TagBytes = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready = 1'b1;
  logic           busy;

  int n_checks = 0;
  int n_fail = 0;
  int n_tx = 0;
  logic prev_tx_valid = 1'b0;

  logic [8:0]  src_mem [N][16];
  int          src_wr [N];
  int          src_rd [N];
  logic [10:0] exp_q [$];
  int          frame_cnt = 0;

  uart_tx_arbiter #(.N_REQ(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .grant    (grant),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Requester sources: a byte is presented until the DUT strobes req_ready; reset discards all.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]      = (src_rd[i] != src_wr[i]);
      req_last[i]       = src_mem[i][src_rd[i] % 16][8];
      req_data[8*i +: 8] = src_mem[i][src_rd[i] % 16][7:0];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) src_rd[i] <= src_wr[i];
      else if (req_ready[i]) src_rd[i] <= src_rd[i] + 1;
    end
  end

  // Transmitter: busy for Frame cycles after each accepted start strobe.
  always @(posedge clk) begin
    if (frame_cnt > 0) begin
      frame_cnt <= frame_cnt - 1;
      if (frame_cnt == 1) tx_ready <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      tx_ready  <= 1'b0;
      frame_cnt <= Frame;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_src(input int i, input logic [7:0] d, input logic last);
    src_mem[i][src_wr[i] % 16] = {last, d};
    src_wr[i] = src_wr[i] + 1;
  endtask

  task automatic exp_byte(input int g, input logic [7:0] d);
    exp_q.push_back({3'(g), d});
  endtask

  task automatic exp_msg_start(input int g);
    if (TagBytes != 0) exp_byte(g, 8'hA0 | 8'(g));
  endtask

  // One cycle: sample at the falling edge and run the per-cycle protocol and scoreboard checks.
  task automatic step();
    logic [10:0] e;
    @(negedge clk);
    chk("req_ready_owner", 32'(req_ready & ~grant), 0);
    chk("grant_onehot0", 32'($onehot0(grant)), 1);
    if (tx_valid) begin
      n_tx++;
      chk("tx_valid_gap", 32'(prev_tx_valid), 0);
      chk("tx_valid_ready", 32'(tx_ready), 1);
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_byte", 32'(tx_data), 32'h100);
      end else begin
        e = exp_q.pop_front();
        chk("sb_tx_data", 32'(tx_data), 32'(e[7:0]));
        chk("sb_tx_grant", 32'(grant), 32'(4'b0001 << e[10:8]));
      end
    end
    prev_tx_valid = tx_valid;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    steps(2);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 3000;
    while (budget > 0 && !(exp_q.size() == 0 && !busy && tx_ready)) begin
      step();
      budget--;
    end
    chk(tag, 32'(budget > 0), 1);
    chk({tag, "_left"}, 32'(exp_q.size()), 0);
  endtask

  task automatic wait_tx(input string tag, input int target);
    int budget;
    budget = 500;
    while (budget > 0 && n_tx < target) begin
      step();
      budget--;
    end
    chk(tag, 32'(budget > 0), 1);
  endtask

  initial begin
    int n0;
    for (int i = 0; i < N; i++) begin
      src_wr[i] = 0;
      for (int j = 0; j < 16; j++) src_mem[i][j] = 9'h000;
    end

    // Reset values while held in reset.
    steps(2);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    steps(2);

    // Single byte from requester 1: exact latency, release afterwards.
    n0 = n_tx;
    push_src(1, 8'h55, 1'b1);
    exp_msg_start(1);
    exp_byte(1, 8'h55);
    step();
    chk("lat_grant_c1", 32'(grant), 32'h2);
    chk("lat_busy_c1", 32'(busy), 1);
`ifndef UART_ARB_TAG_EN
    chk("lat_req_ready_c1", 32'(req_ready), 32'h2);
    step();
    chk("lat_tx_valid_c2", 32'(tx_valid), 1);
    chk("lat_tx_data_c2", 32'(tx_data), 32'h55);
`endif
    drain("t1_drain");
    chk("t1_grant_released", 32'(grant), 0);
    chk("t1_strobes", 32'(n_tx - n0), 32'(1 + TagBytes));

    // Requesters 0 and 2, two-byte messages each, presented together.
    do_reset();
    push_src(0, 8'h11, 1'b0);
    push_src(0, 8'h12, 1'b1);
    push_src(2, 8'h21, 1'b0);
    push_src(2, 8'h22, 1'b1);
    exp_msg_start(0);
    exp_byte(0, 8'h11);
    exp_byte(0, 8'h12);
    exp_msg_start(2);
    exp_byte(2, 8'h21);
    exp_byte(2, 8'h22);
    drain("t2_drain");

    // All four with back-to-back single-byte messages: strict rotation.
    do_reset();
    for (int i = 0; i < N; i++) begin
      push_src(i, 8'h40 + 8'(i), 1'b1);
      push_src(i, 8'h50 + 8'(i), 1'b1);
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        exp_msg_start(i);
        exp_byte(i, (r == 0 ? 8'h40 : 8'h50) + 8'(i));
      end
    end
    drain("t3_drain");

    // Owner stalls mid-message while requester 3 waits.
    do_reset();
    n0 = n_tx;
    push_src(1, 8'h31, 1'b0);
    push_src(3, 8'h3F, 1'b1);
    exp_msg_start(1);
    exp_byte(1, 8'h31);
    wait_tx("t4_first_byte", n0 + 1 + TagBytes);
    n0 = n_tx;
    steps(1000);
    chk("t4_no_tx_while_stalled", 32'(n_tx - n0), 0);
    chk("t4_grant_held", 32'(grant), 32'h2);
    chk("t4_busy_held", 32'(busy), 1);
    push_src(1, 8'h32, 1'b1);
    exp_byte(1, 8'h32);
    exp_msg_start(3);
    exp_byte(3, 8'h3F);
    drain("t4_drain");

    // Reset during WAIT_LO, then a tie between requesters 0 and 1.
    do_reset();
    n0 = n_tx;
    push_src(0, 8'h01, 1'b0);
    push_src(0, 8'h02, 1'b1);
    exp_msg_start(0);
    exp_byte(0, 8'h01);
    wait_tx("t5_first_byte", n0 + 1 + TagBytes);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_abort_grant", 32'(grant), 0);
    chk("t5_abort_req_ready", 32'(req_ready), 0);
    chk("t5_abort_tx_valid", 32'(tx_valid), 0);
    chk("t5_abort_tx_data", 32'(tx_data), 0);
    chk("t5_abort_busy", 32'(busy), 0);
    steps(2);
    exp_q.delete();
    rst_n = 1'b1;
    push_src(0, 8'h0A, 1'b1);
    push_src(1, 8'h1B, 1'b1);
    exp_msg_start(0);
    exp_byte(0, 8'h0A);
    exp_msg_start(1);
    exp_byte(1, 8'h1B);
    step();
    chk("t5_tie_grant", 32'(grant), 32'h1);
    drain("t5_drain");

`ifdef UART_ARB_TAG_EN
    // Tagged message from requester 2.
    do_reset();
    n0 = n_tx;
    push_src(2, 8'h7E, 1'b1);
    exp_msg_start(2);
    exp_byte(2, 8'h7E);
    drain("t6_drain");
    chk("t6_strobes", 32'(n_tx - n0), 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
